jump_power_meter: RTL and testbench

JUMP_POWER_METER -- requirements
Module: jump_power_meter

---
 rtl/jump_power_meter_pkg.sv | 35 +++
 rtl/tick_gen.sv | 37 +++
 rtl/jump_power_meter.sv | 128 ++++++++++++
 tb/tb_jump_power_meter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_power_meter_pkg.sv
// ============================================================================
// jump_power_meter_pkg : shared game constants, FSM encoding, charge helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package jump_power_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CHARGE   = 2'd1,
      ST_COOLDOWN = 2'd2
   } state_t;

   localparam int DEF_TICK_DIV       = 500000;
   localparam int DEF_MIN_TICKS      = 2;
   localparam int DEF_COOLDOWN_TICKS = 20;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Bit k lights once the charge passes 32*k, so bit 0 means "any charge".
   function automatic logic [7:0] thermometer(input logic [7:0] v);
      logic [7:0] t;
      t = '0;
      for (int k = 0; k < 8; k++) begin
         t[k] = (int'(v) > 32 * k);
      end
      return t;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// tick_gen : free-running 0..TICK_DIV-1 prescaler with a one-clk tick
// Revision: 1.0
// ============================================================================
`default_nettype none

module tick_gen
   import jump_power_meter_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic clr,
   input  logic restart,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (clr || restart) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/jump_power_meter.sv
// ============================================================================
// jump_power_meter : measures jump-button hold time in ticks and latches it
// Revision: 1.0
// ============================================================================
`default_nettype none

module jump_power_meter
   import jump_power_meter_pkg::*;
#(
   parameter int TICK_DIV       = DEF_TICK_DIV,
   parameter int MIN_TICKS      = DEF_MIN_TICKS,
   parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       btn_level,
   input  logic       enable,
   output logic [7:0] jump_dist,
   output logic       dist_valid,
   output logic       jump_seq,
   output logic       charging,
   output logic [7:0] charge_bar
);

   localparam int CDW = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS + 1) : 1;

   state_t           state, state_nxt;
   logic             btn_d;
   logic             btn_rise;
   logic             tick;
   logic             restart;
   logic             latch;
   logic             cool_clr;
   logic             cool_inc;
   logic [7:0]       charge_cnt;
   logic [7:0]       charge_tick;
   logic [CDW-1:0]   cool_cnt;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .clr     (clr),
      .restart (restart),
      .tick    (tick)
   );

   assign btn_rise = btn_level & ~btn_d;
   // A tick landing on the release cycle still counts toward the latched value.
   assign charge_tick = tick ? sat_inc(charge_cnt) : charge_cnt;

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      restart   = 1'b0;
      latch     = 1'b0;
      cool_clr  = 1'b0;
      cool_inc  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable && btn_rise) begin
               state_nxt = ST_CHARGE;
               restart   = 1'b1;
            end
         end
         ST_CHARGE: begin
            if (!enable) begin
               state_nxt = ST_IDLE;
            end else if (!btn_level) begin
               state_nxt = ST_COOLDOWN;
               cool_clr  = 1'b1;
               latch     = (int'(charge_tick) >= MIN_TICKS);
            end
         end
         ST_COOLDOWN: begin
            if (tick) begin
               if (int'(cool_cnt) + 1 >= COOLDOWN_TICKS) begin
                  state_nxt = ST_IDLE;
               end else begin
                  cool_inc = 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         btn_d      <= 1'b0;
         charge_cnt <= 8'd0;
         cool_cnt   <= '0;
         jump_dist  <= 8'd0;
         dist_valid <= 1'b0;
         jump_seq   <= 1'b0;
      end else begin
         btn_d      <= btn_level;
         dist_valid <= latch;
         if (latch) begin
            jump_dist <= charge_tick;
            jump_seq  <= ~jump_seq;
         end
         if (state == ST_CHARGE && state_nxt == ST_CHARGE) begin
            charge_cnt <= charge_tick;
         end else begin
            charge_cnt <= 8'd0;
         end
         if (cool_clr) begin
            cool_cnt <= '0;
         end else if (cool_inc) begin
            cool_cnt <= cool_cnt + CDW'(1);
         end
      end
   end

   assign charging   = (state == ST_CHARGE);
   assign charge_bar = charging ? thermometer(charge_cnt) : 8'd0;

endmodule

`default_nettype wire

// File: tb/tb_jump_power_meter.sv
// ============================================================================
// tb_jump_power_meter : directed scenarios with hand-computed expectations
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_jump_power_meter;

   logic       clk = 1'b0;
   logic       clr;
   logic       btn_level;
   logic       enable;
   logic [7:0] jump_dist;
   logic       dist_valid;
   logic       jump_seq;
   logic       charging;
   logic [7:0] charge_bar;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   jump_power_meter #(
      .TICK_DIV       (4),
      .MIN_TICKS      (2),
      .COOLDOWN_TICKS (3)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .btn_level  (btn_level),
      .enable     (enable),
      .jump_dist  (jump_dist),
      .dist_valid (dist_valid),
      .jump_seq   (jump_seq),
      .charging   (charging),
      .charge_bar (charge_bar)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dist_valid === 1'b1) pulses <= pulses + 1;
   end

   // Press starting at the current negedge, held through n rising edges.
   task automatic hold(input int n);
      btn_level = 1'b1;
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic release_check(input logic exp_dv, input logic [7:0] exp_dist,
                                input logic exp_seq, input string name);
      btn_level = 1'b0;
      @(negedge clk);
      checks++;
      if (dist_valid !== exp_dv) begin
         errors++;
         $display("FAIL %s_valid: got %b expected %b", name, dist_valid, exp_dv);
      end
      checks++;
      if (jump_dist !== exp_dist) begin
         errors++;
         $display("FAIL %s_dist: got %0d expected %0d", name, jump_dist, exp_dist);
      end
      checks++;
      if (jump_seq !== exp_seq) begin
         errors++;
         $display("FAIL %s_seq: got %b expected %b", name, jump_seq, exp_seq);
      end
      @(negedge clk);
      checks++;
      if (dist_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_pulse_width: got %b expected 0", name, dist_valid);
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset;
      clr = 1'b1; btn_level = 1'b0; enable = 1'b0;
      repeat (3) @(negedge clk);
      clr = 1'b0;
      checks++;
      if ({jump_dist, dist_valid, jump_seq, charging, charge_bar} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs: got dist=%0d dv=%b seq=%b chg=%b bar=%b expected all 0",
                  jump_dist, dist_valid, jump_seq, charging, charge_bar);
      end
   endtask

   task automatic test_tap_cooldown;
      int p0;
      logic seen;
      p0 = pulses;
      enable = 1'b1;
      @(negedge clk);
      hold(4);
      checks++;
      if (charging !== 1'b1) begin
         errors++;
         $display("FAIL tap_charging: got %b expected 1", charging);
      end
      btn_level = 1'b0;
      @(negedge clk);
      checks++;
      if (dist_valid !== 1'b0 || charging !== 1'b0) begin
         errors++;
         $display("FAIL tap_discard: got dv=%b chg=%b expected 0 0", dist_valid, charging);
      end
      // Press during cooldown, held past its end: must never start a charge.
      btn_level = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (charging === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL cooldown_press: got charging=1 expected 0");
      end
      btn_level = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (pulses !== p0 || jump_dist !== 8'd0) begin
         errors++;
         $display("FAIL tap_no_update: got pulses=%0d dist=%0d expected %0d 0",
                  pulses - p0, jump_dist, 0);
      end
      // Tap again, then a press 13 clocks later must find IDLE.
      hold(4);
      btn_level = 1'b0;
      repeat (13) @(negedge clk);
      btn_level = 1'b1;
      @(negedge clk);
      checks++;
      if (charging !== 1'b1) begin
         errors++;
         $display("FAIL cooldown_exit: got charging=%b expected 1", charging);
      end
      enable = 1'b0;
      @(negedge clk);
      btn_level = 1'b0;
      enable = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_enable;
      int p0;
      p0 = pulses;
      enable = 1'b0;
      btn_level = 1'b1;
      repeat (12) @(negedge clk);
      checks++;
      if (charging !== 1'b0) begin
         errors++;
         $display("FAIL disabled_press: got charging=%b expected 0", charging);
      end
      enable = 1'b1;
      repeat (12) @(negedge clk);
      checks++;
      if (charging !== 1'b0) begin
         errors++;
         $display("FAIL enable_rise_held: got charging=%b expected 0", charging);
      end
      btn_level = 1'b0;
      repeat (4) @(negedge clk);
      hold(12);
      checks++;
      if (charging !== 1'b1 || charge_bar !== 8'b0000_0001) begin
         errors++;
         $display("FAIL abort_pre: got chg=%b bar=%b expected 1 00000001", charging, charge_bar);
      end
      enable = 1'b0;
      @(negedge clk);
      checks++;
      if (charging !== 1'b0 || charge_bar !== 8'd0) begin
         errors++;
         $display("FAIL abort_idle: got chg=%b bar=%b expected 0 00000000", charging, charge_bar);
      end
      btn_level = 1'b0;
      enable = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (pulses !== p0 || jump_dist !== 8'd0 || jump_seq !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_update: got pulses=%0d dist=%0d seq=%b expected 0 0 0",
                  pulses - p0, jump_dist, jump_seq);
      end
   endtask

   task automatic test_basic;
      int p0;
      p0 = pulses;
      hold(40);
      checks++;
      if (charge_bar !== 8'b0000_0001) begin
         errors++;
         $display("FAIL basic_bar: got %b expected 00000001", charge_bar);
      end
      release_check(1'b1, 8'd10, 1'b1, "basic");
      checks++;
      if (pulses !== p0 + 1) begin
         errors++;
         $display("FAIL basic_pulses: got %0d expected 1", pulses - p0);
      end
   endtask

   task automatic test_saturate;
      hold(1200);
      checks++;
      if (charge_bar !== 8'hFF) begin
         errors++;
         $display("FAIL sat_bar: got %b expected 11111111", charge_bar);
      end
      release_check(1'b1, 8'd255, 1'b0, "saturate");
   endtask

   task automatic test_clr_mid;
      int p0;
      p0 = pulses;
      hold(28);
      checks++;
      if (charging !== 1'b1) begin
         errors++;
         $display("FAIL clr_pre: got charging=%b expected 1", charging);
      end
      clr = 1'b1;
      btn_level = 1'b0;
      @(negedge clk);
      checks++;
      if ({jump_dist, dist_valid, jump_seq, charging, charge_bar} !== 19'd0) begin
         errors++;
         $display("FAIL clr_outputs: got dist=%0d dv=%b seq=%b chg=%b bar=%b expected all 0",
                  jump_dist, dist_valid, jump_seq, charging, charge_bar);
      end
      clr = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (pulses !== p0) begin
         errors++;
         $display("FAIL clr_no_pulse: got %0d expected 0", pulses - p0);
      end
      hold(16);
      release_check(1'b1, 8'd4, 1'b1, "after_clr");
   endtask

   task automatic test_back_to_back;
      int p0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      p0 = pulses;
      hold(12);
      release_check(1'b1, 8'd3, 1'b1, "b2b_first");
      hold(24);
      release_check(1'b1, 8'd6, 1'b0, "b2b_second");
      checks++;
      if (pulses !== p0 + 2) begin
         errors++;
         $display("FAIL b2b_pulses: got %0d expected 2", pulses - p0);
      end
   endtask

   initial begin
      clr = 1'b1;
      btn_level = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      test_reset();
      test_tap_cooldown();
      test_enable();
      test_basic();
      test_saturate();
      test_clr_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
